// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register file / PSR block.
//   - PSR flag bit indices (carry, link, flag, zero, negative)
//   - default PSR width
//   - sequencer state enum
package regfile_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    localparam int unsigned FLAG_W_DEF = 5;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/regfile_psr_if.sv
// regfile_psr_if: bus between decode/writeback and the register file / PSR.
//   master (decode + writeback side) drives:
//     reg_write, wr_addr, wr_data  - write port
//     src_addr, dst_addr           - read addresses
//     flag_we, flags_in            - masked PSR update
//   slave (register file) drives:
//     src_data, dst_data           - combinational read data
//     flags_out                    - registered PSR
//     init_busy                    - clear sequencer running
interface regfile_psr_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned FLAG_W = FLAG_W_DEF
);
    logic              reg_write;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [WIDTH-1:0]  src_data;
    logic [WIDTH-1:0]  dst_data;
    logic [FLAG_W-1:0] flag_we;
    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] flags_out;
    logic              init_busy;

    modport master (
        output reg_write, wr_addr, wr_data, src_addr, dst_addr, flag_we, flags_in,
        input  src_data, dst_data, flags_out, init_busy
    );

    modport slave (
        input  reg_write, wr_addr, wr_data, src_addr, dst_addr, flag_we, flags_in,
        output src_data, dst_data, flags_out, init_busy
    );

endinterface

// File: rtl/psr_reg.sv
// psr_reg: processor status register with per-bit write mask.
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset, clears all flags
//   i_we     - per-bit write mask
//   i_flags  - new flag values, taken where i_we is set
//   o_flags  - registered flag contents
module psr_reg
    import regfile_pkg::*;
#(
    parameter int unsigned FLAG_W = FLAG_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FLAG_W-1:0] i_we,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [FLAG_W-1:0] o_flags
);
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_flags_next;

    always_comb begin
        w_flags_next = (r_flags & ~i_we) | (i_flags & i_we);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_next;
        end
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/regfile_psr.sv
// regfile_psr: DEPTH x WIDTH register file (2 combinational read ports, 1 write port with
// write-through bypass) merged with a masked-update PSR. After reset a sequencer clears one
// array entry per cycle so the array itself carries no reset and can map to RAM/LUTRAM.
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset (restarts the clear sequence)
//   bus      - regfile_psr_if.slave: write port, read ports, PSR update, init_busy
// Optional build macro: ZERO_REG_EN - register 0 hardwired to zero, writes to it dropped.
module regfile_psr
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned FLAG_W = FLAG_W_DEF
) (
    input logic          i_clk,
    input logic          i_rst_n,
    regfile_psr_if.slave bus
);
    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic              r_init_busy;

    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_run;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_data;
    logic [WIDTH-1:0]  w_src_data;
    logic [WIDTH-1:0]  w_dst_data;
    logic [FLAG_W-1:0] w_flag_we;
    logic [FLAG_W-1:0] w_flags;

    // Sequencer: walk every entry once, then stay in RUN until the next reset.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            ST_INIT: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_init_busy <= (w_state_next == ST_INIT);
        end
    end

    assign w_run = (r_state == ST_RUN);

    // Single shared write port: the sequencer owns it during INIT, writeback during RUN.
    always_comb begin
`ifdef ZERO_REG_EN
        w_wr_ok = bus.reg_write && (bus.wr_addr != '0);
`else
        w_wr_ok = bus.reg_write;
`endif
        if (w_run) begin
            w_mem_we   = w_wr_ok;
            w_mem_addr = bus.wr_addr;
            w_mem_data = bus.wr_data;
        end else begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_cnt;
            w_mem_data = '0;
        end
    end

    // No reset on the array so it stays RAM-inferable.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Read ports: array value, overridden by same-cycle write data, forced to 0 outside RUN.
    always_comb begin
        w_src_data = r_mem[bus.src_addr];
        w_dst_data = r_mem[bus.dst_addr];
        if (bus.reg_write && (bus.wr_addr == bus.src_addr)) begin
            w_src_data = bus.wr_data;
        end
        if (bus.reg_write && (bus.wr_addr == bus.dst_addr)) begin
            w_dst_data = bus.wr_data;
        end
`ifdef ZERO_REG_EN
        if (bus.src_addr == '0) begin
            w_src_data = '0;
        end
        if (bus.dst_addr == '0) begin
            w_dst_data = '0;
        end
`endif
        if (!w_run) begin
            w_src_data = '0;
            w_dst_data = '0;
        end
    end

    assign w_flag_we = w_run ? bus.flag_we : '0;

    psr_reg #(
        .FLAG_W (FLAG_W)
    ) u_psr_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_flag_we),
        .i_flags (bus.flags_in),
        .o_flags (w_flags)
    );

    assign bus.src_data  = w_src_data;
    assign bus.dst_data  = w_dst_data;
    assign bus.flags_out = w_flags;
    assign bus.init_busy = r_init_busy;

endmodule

// File: tb/tb_regfile_psr.sv
// tb_regfile_psr: scoreboard bench for regfile_psr. The driver applies one set of inputs per
// cycle, predicts the outputs from a behavioural model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_regfile_psr;
    import regfile_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FLAG_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_psr_if #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FLAG_W (FLAG_W)
    ) bus ();

    regfile_psr #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FLAG_W (FLAG_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [WIDTH-1:0]  src;
        logic [WIDTH-1:0]  dst;
        logic [FLAG_W-1:0] flags;
        logic              busy;
        string             tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: register contents, PSR, and cycles left before the array is usable.
    logic [WIDTH-1:0]  m_mem [DEPTH];
    logic [FLAG_W-1:0] m_flags = '0;
    int                m_init_left = DEPTH;

`ifdef ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_W-1:0] a,
                                                    input bit we,
                                                    input logic [ADDR_W-1:0] wa,
                                                    input logic [WIDTH-1:0] wd);
        if (m_init_left > 0) return '0;
        if (ZeroReg && a == 0) return '0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cycle(input bit rst, input bit we, input logic [ADDR_W-1:0] wa,
                         input logic [WIDTH-1:0] wd, input logic [ADDR_W-1:0] sa,
                         input logic [ADDR_W-1:0] da, input logic [FLAG_W-1:0] fwe,
                         input logic [FLAG_W-1:0] fin, input string tag);
        exp_t e;
        rst_n         = !rst;
        bus.reg_write = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.src_addr  = sa;
        bus.dst_addr  = da;
        bus.flag_we   = fwe;
        bus.flags_in  = fin;
        if (rst) begin
            m_flags     = '0;
            m_init_left = DEPTH;
        end
        e.src   = model_read(sa, we, wa, wd);
        e.dst   = model_read(da, we, wa, wd);
        e.flags = m_flags;
        e.busy  = (m_init_left > 0);
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end else begin
                if (we && !(ZeroReg && wa == 0)) m_mem[wa] = wd;
                m_flags = (m_flags & ~fwe) | (fin & fwe);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [ADDR_W-1:0] sa,
                        input logic [ADDR_W-1:0] da, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, sa, da, '0, '0, tag);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " src"},   32'(bus.src_data),  32'(e.src));
            check({e.tag, " dst"},   32'(bus.dst_data),  32'(e.dst));
            check({e.tag, " flags"}, 32'(bus.flags_out), 32'(e.flags));
            check({e.tag, " busy"},  32'(bus.init_busy), 32'(e.busy));
        end
    end

    localparam logic [FLAG_W-1:0] AllFlags = '1;

    initial begin
        logic [FLAG_W-1:0] fin_a;
        logic [FLAG_W-1:0] fin_b;
        logic [FLAG_W-1:0] fwe_b;
        bus.reg_write = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.flag_we   = '0;
        bus.flags_in  = '0;
        @(posedge clk);
        #1;

        // Reset, release, writes and flag updates during INIT must be ignored.
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, '0, '0, '0, '0, "reset");
        idle(2, 3, 3, "init");
        cycle(0, 1, 4'd3, 16'hBEEF, 4'd3, 4'd3, AllFlags, AllFlags, "init_wr");
        idle(13, 3, 3, "init");
        for (int i = 0; i < DEPTH; i += 2) begin
            idle(1, ADDR_W'(i), ADDR_W'(i + 1), "clear_rd");
        end
        idle(1, 4'd3, 4'd3, "r3_after_init");

        // Basic write then read.
        cycle(0, 1, 4'd1, 16'h0001, 4'd0, 4'd0, '0, '0, "wr_r1");
        cycle(0, 1, 4'd2, 16'h0002, 4'd0, 4'd0, '0, '0, "wr_r2");
        idle(1, 4'd1, 4'd2, "rd_r1_r2");

        // Same-cycle write-through on both ports, then the stored value.
        cycle(0, 1, 4'd5, 16'hA5A5, 4'd5, 4'd5, '0, '0, "bypass");
        idle(1, 4'd5, 4'd5, "after_bypass");

        // PSR masking.
        fin_a = FLAG_W'((1 << FLAG_N) | (1 << FLAG_F) | (1 << FLAG_C));
        fin_b = FLAG_W'((1 << FLAG_Z) | (1 << FLAG_L));
        fwe_b = FLAG_W'(1 << FLAG_L);
        cycle(0, 0, '0, '0, '0, '0, AllFlags, fin_a, "psr_all");
        cycle(0, 0, '0, '0, '0, '0, fwe_b, fin_b, "psr_mask");
        check("psr_direct", 32'(bus.flags_out), 32'h17);
        idle(1, '0, '0, "psr_hold");

        // Reset pulsed mid-INIT after r4 was written.
        cycle(0, 1, 4'd4, 16'h1234, 4'd4, 4'd4, '0, '0, "wr_r4");
        idle(1, 4'd4, 4'd4, "rd_r4");
        cycle(1, 0, '0, '0, 4'd4, 4'd4, '0, '0, "reset2");
        idle(7, 4'd4, 4'd4, "init2");
        cycle(1, 0, '0, '0, 4'd4, 4'd4, '0, '0, "reset3");
        idle(DEPTH, 4'd4, 4'd4, "init3");
        idle(1, 4'd4, 4'd4, "r4_cleared");

        // Register 0 write (hardwired to zero only with ZERO_REG_EN).
        cycle(0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0, '0, '0, "wr_r0");
        idle(1, 4'd0, 4'd0, "rd_r0");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit rst;
            rst = ($urandom_range(0, 149) == 0);
            cycle(rst, 1'($urandom_range(0, 1)), ADDR_W'($urandom), WIDTH'($urandom),
                  ADDR_W'($urandom), ADDR_W'($urandom), FLAG_W'($urandom), FLAG_W'($urandom),
                  "random");
        end
        idle(2, '0, '0, "drain");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
